// File: rtl/conv_pkg.sv
// conv_pkg: shared types and default sizes for the convolution datapath
// control. CONV_NOUT is the number of results produced per buffer fill.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAC   = 3'd1,
    DRAIN = 3'd2,
    OUT   = 3'd3,
    REL   = 3'd4
  } conv_seq_state_t;

  localparam int CONV_N    = 8;
  localparam int CONV_M    = 4;
  localparam int CONV_NOUT = CONV_N - CONV_M + 1;

endpackage

// File: rtl/conv_sequencer.sv
// conv_sequencer: sequences one multiply-accumulate per cycle over the X and
// F operand buffers, holds each result on a valid/ready handshake, and
// releases the buffers back to their write controllers after the last result.
//
// Handshake: a result transfers on a rising clk edge where m_valid_y and
// m_ready_y are both high; m_valid_y never drops before that edge and
// m_ready_y is ignored while m_valid_y is low.
//
// Optional feature: define CONV_SEQ_STALL_CNT_EN to add the 16-bit stall_cnt
// port, a saturating count of cycles where a result waits for m_ready_y.
//
// Debug: the FSM state is held in state_q (type conv_seq_state_t).
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int N    = CONV_N,
  parameter int M    = CONV_M,
  parameter int LOGN = 3,
  parameter int LOGM = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            full_x,
  input  logic            full_f,
  output logic            rd_active,
  output logic [LOGN-1:0] rd_addr_x,
  output logic [LOGM-1:0] rd_addr_f,
  output logic            acc_en,
  output logic            acc_clr,
  output logic            m_valid_y,
  input  logic            m_ready_y,
  output logic            buf_release
`ifdef CONV_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);

  conv_seq_state_t state_q;
  logic [LOGN-1:0] base_q;
  logic [LOGN-1:0] rd_addr_x_q;
  logic [LOGM-1:0] rd_addr_f_q;
  logic            rd_active_q;
  logic            acc_en_q;
  logic            acc_clr_q;
  logic            m_valid_q;
  logic            buf_release_q;

  localparam logic [LOGN-1:0] LAST_BASE = LOGN'(N - M);
  localparam logic [LOGM-1:0] LAST_TAP  = LOGM'(M - 1);

  // Main FSM with all outputs registered. Addresses hold through DRAIN so the
  // last presented tap is visible, and are parked at zero outside a MAC span.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      base_q        <= '0;
      rd_addr_x_q   <= '0;
      rd_addr_f_q   <= '0;
      rd_active_q   <= 1'b0;
      m_valid_q     <= 1'b0;
      buf_release_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (full_x && full_f) begin
            state_q     <= MAC;
            base_q      <= '0;
            rd_addr_x_q <= '0;
            rd_addr_f_q <= '0;
            rd_active_q <= 1'b1;
          end
        end
        MAC: begin
          if (rd_addr_f_q == LAST_TAP) begin
            state_q     <= DRAIN;
            rd_active_q <= 1'b0;
          end else begin
            rd_addr_x_q <= rd_addr_x_q + 1'b1;
            rd_addr_f_q <= rd_addr_f_q + 1'b1;
          end
        end
        DRAIN: begin
          state_q     <= OUT;
          m_valid_q   <= 1'b1;
          rd_addr_x_q <= '0;
          rd_addr_f_q <= '0;
        end
        OUT: begin
          if (m_ready_y) begin
            m_valid_q <= 1'b0;
            if (base_q == LAST_BASE) begin
              state_q       <= REL;
              buf_release_q <= 1'b1;
            end else begin
              state_q     <= MAC;
              base_q      <= base_q + 1'b1;
              rd_addr_x_q <= base_q + 1'b1;
              rd_addr_f_q <= '0;
              rd_active_q <= 1'b1;
            end
          end
        end
        REL: begin
          state_q       <= IDLE;
          buf_release_q <= 1'b0;
        end
        default: begin
          state_q       <= IDLE;
          rd_active_q   <= 1'b0;
          m_valid_q     <= 1'b0;
          buf_release_q <= 1'b0;
        end
      endcase
    end
  end

  // Accumulator strobes trail the MAC cycles by one to match the one-cycle
  // synchronous buffer read; clear marks the product of tap 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_en_q  <= 1'b0;
      acc_clr_q <= 1'b0;
    end else begin
      acc_en_q  <= (state_q == MAC);
      acc_clr_q <= (state_q == MAC) && (rd_addr_f_q == '0);
    end
  end

  assign rd_active   = rd_active_q;
  assign rd_addr_x   = rd_addr_x_q;
  assign rd_addr_f   = rd_addr_f_q;
  assign acc_en      = acc_en_q;
  assign acc_clr     = acc_clr_q;
  assign m_valid_y   = m_valid_q;
  assign buf_release = buf_release_q;

`ifdef CONV_SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;

  // Next stall count: one more for each cycle a result waits, saturating.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (m_valid_q && !m_ready_y && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
